// File: rtl/while_seq_ent.sv
// Clocked form of the unrolled-while loop entity. It runs temp += STEP once per cycle for
// COUNT cycles, then returns temp*A - B (mod 2^NBITS) through a valid/ready handshake.
module while_seq_ent #(
    parameter int NBITS  = 8,
    parameter int CWIDTH = 4,
    parameter int INIT   = 1,
    parameter int STEP   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [CWIDTH-1:0] COUNT,
    input  logic [NBITS-1:0]  A,
    input  logic [NBITS-1:0]  B,
    output logic              BUSY,
    output logic              VALID,
    input  logic              READY,
    output logic [NBITS-1:0]  XOUT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOP,
        S_CALC,
        S_HOLD
    } state_t;

    localparam logic [NBITS-1:0]  C_INIT = NBITS'(INIT);
    localparam logic [NBITS-1:0]  C_STEP = NBITS'(STEP);
    localparam logic [CWIDTH-1:0] C_ONE  = CWIDTH'(1);

    state_t            r_state;
    logic [NBITS-1:0]  r_temp;
    logic [CWIDTH-1:0] r_iter;
    logic [CWIDTH-1:0] r_count;
    logic [NBITS-1:0]  r_a;
    logic [NBITS-1:0]  r_b;
    logic [NBITS-1:0]  r_xout;
    logic              r_valid;

    logic              w_last;
    logic [NBITS-1:0]  w_prod;
    logic [NBITS-1:0]  w_result;

    assign w_last   = (r_iter == r_count - C_ONE);
    // Only the low NBITS of the full product survive, so an NBITS-wide multiply is exact.
    assign w_prod   = r_temp * r_a;
    assign w_result = w_prod - r_b;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_temp  <= '0;
            r_iter  <= '0;
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_xout  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_count <= COUNT;
                        r_temp  <= C_INIT;
                        r_iter  <= '0;
                        r_state <= (COUNT == '0) ? S_CALC : S_LOOP;
                    end
                end
                S_LOOP: begin
                    r_temp <= r_temp + C_STEP;
                    r_iter <= r_iter + C_ONE;
                    if (w_last) r_state <= S_CALC;
                end
                S_CALC: begin
                    r_xout  <= w_result;
                    r_valid <= 1'b1;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_valid && READY) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BUSY  = (r_state != S_IDLE);
    assign VALID = r_valid;
    assign XOUT  = r_xout;

endmodule

// File: tb/tb_while_seq_ent.sv
// Directed bench for while_seq_ent: default-parameter instance plus a 16-bit,
// STEP=3 instance, covering latency, wraps, backpressure and asynchronous reset.
module tb_while_seq_ent;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [3:0]  COUNT = '0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic        READY = 1'b0;
    logic        BUSY;
    logic        VALID;
    logic [7:0]  XOUT;

    logic        START2 = 1'b0;
    logic [5:0]  COUNT2 = '0;
    logic [15:0] A2 = '0;
    logic [15:0] B2 = '0;
    logic        READY2 = 1'b1;
    logic        BUSY2;
    logic        VALID2;
    logic [15:0] XOUT2;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    while_seq_ent dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .COUNT(COUNT), .A(A), .B(B),
        .BUSY(BUSY), .VALID(VALID), .READY(READY), .XOUT(XOUT)
    );

    while_seq_ent #(.NBITS(16), .CWIDTH(6), .INIT(0), .STEP(3)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .START(START2), .COUNT(COUNT2), .A(A2), .B(B2),
        .BUSY(BUSY2), .VALID(VALID2), .READY(READY2), .XOUT(XOUT2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Launch a run and wait (bounded) for VALID; optionally complete the handshake.
    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] c, input logic [7:0] exp, input bit ack,
                       input bit watch_busy);
        int lat;
        A = a; B = b; COUNT = c; START = 1'b1;
        tick();
        START = 1'b0;
        chk({tag, "_busy_start"}, BUSY, 1);
        lat = 0;
        while (VALID !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            if (watch_busy) chk({tag, "_busy_run"}, BUSY, 1);
        end
        chk({tag, "_latency"}, lat, c + 1);
        chk({tag, "_xout"}, XOUT, exp);
        if (ack) begin
            tick();
            chk({tag, "_valid_drop"}, VALID, 0);
            chk({tag, "_busy_drop"}, BUSY, 0);
        end
    endtask

    initial begin
        int lat;
        #3;
        chk("rst_busy", BUSY, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_xout", XOUT, 0);
        chk("rst_busy2", BUSY2, 0);
        #10 RST_N = 1'b1;
        tick();

        READY = 1'b1;
        run("dflt", 8'd3, 8'd5, 4'd4, 8'd10, 1'b1, 1'b0);
        run("pwrap", 8'd200, 8'd0, 4'd4, 8'd232, 1'b1, 1'b0);
        run("subwrap", 8'd1, 8'd10, 4'd0, 8'd247, 1'b1, 1'b0);
        run("maxcnt", 8'd16, 8'd1, 4'd15, 8'd255, 1'b1, 1'b1);

        // Backpressure: hold READY low while inputs and START toggle in HOLD.
        READY = 1'b0;
        run("bp", 8'd3, 8'd5, 4'd4, 8'd10, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            A = A + 8'd37; B = B ^ 8'h5A; START = ~START;
            tick();
            chk("bp_valid_hold", VALID, 1);
            chk("bp_xout_hold", XOUT, 10);
            chk("bp_busy_hold", BUSY, 1);
        end
        START = 1'b0;
        READY = 1'b1;
        tick();
        chk("bp_valid_drop", VALID, 0);
        chk("bp_busy_drop", BUSY, 0);
        run("bp_next", 8'd2, 8'd1, 4'd1, 8'd3, 1'b1, 1'b0);

        // Asynchronous reset between edges in the middle of a 4-iteration loop.
        A = 8'd3; B = 8'd5; COUNT = 4'd4; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        chk("arst_busy_before", BUSY, 1);
        chk("arst_xout_before", XOUT, 3);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_busy", BUSY, 0);
        chk("arst_valid", VALID, 0);
        chk("arst_xout", XOUT, 0);
        #3 RST_N = 1'b1;
        tick();
        chk("arst_idle", BUSY, 0);
        run("arst_rerun", 8'd3, 8'd5, 4'd4, 8'd10, 1'b1, 1'b0);

        // Non-default parameters on the second instance.
        A2 = 16'd1000; B2 = 16'd7; COUNT2 = 6'd40; START2 = 1'b1;
        tick();
        START2 = 1'b0;
        chk("p16_busy_start", BUSY2, 1);
        lat = 0;
        while (VALID2 !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("p16_latency", lat, 41);
        chk("p16_xout", XOUT2, 54457);
        tick();
        chk("p16_valid_drop", VALID2, 0);
        chk("p16_busy_drop", BUSY2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
